// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and single-port memory bus for mem_arbiter
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-port fixed-latency memory
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic { IDLE, RD_WAIT } state_t;
    typedef enum logic { OWN_IF, OWN_D } owner_t;

    localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

    state_t        state, state_nxt;
    owner_t        owner, owner_nxt;
    logic [1:0]    lat_cnt, lat_nxt;
    logic [3:0]    starve_cnt, starve_nxt;
    logic          capture;
    logic          if_rvalid_q, d_rvalid_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;

    logic          idle_ok, fetch_win, data_win;
    logic [AW-1:0] win_addr;

    // Grants are combinational so a write or read issues in the request cycle.
    always_comb begin
        idle_ok   = (state == IDLE) && !reset;
        fetch_win = idle_ok && bus.if_req && (!bus.d_req || (starve_cnt == STARVE_CAP));
        data_win  = idle_ok && bus.d_req && !fetch_win;
        win_addr  = data_win ? bus.d_addr : bus.if_addr;

        bus.if_gnt  = fetch_win;
        bus.d_gnt   = data_win;
        bus.m_en    = fetch_win || data_win;
        bus.m_we    = data_win && bus.d_we;
        bus.m_addr  = (fetch_win || data_win) ? win_addr : '0;
        bus.m_wdata = (data_win && bus.d_we) ? bus.d_wdata : '0;
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        lat_nxt    = lat_cnt;
        starve_nxt = starve_cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.if_req || fetch_win) begin
                    starve_nxt = '0;
                end else if (starve_cnt < STARVE_CAP) begin
                    starve_nxt = starve_cnt + 4'd1;
                end
                if (fetch_win || (data_win && !bus.d_we)) begin
                    state_nxt = RD_WAIT;
                    lat_nxt   = LAT_INIT;
                    owner_nxt = data_win ? OWN_D : OWN_IF;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    lat_nxt = lat_cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            lat_cnt     <= lat_nxt;
            starve_cnt  <= starve_nxt;
            if_rvalid_q <= capture && (owner == OWN_IF);
            d_rvalid_q  <= capture && (owner == OWN_D);
            // Only the owning port's data register is touched by a capture.
            if (capture && (owner == OWN_IF)) if_rdata_q <= bus.m_rdata;
            if (capture && (owner == OWN_D))  d_rdata_q  <= bus.m_rdata;
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
